// File: rtl/serial_and_reducer_if.sv
// Stream-in / result-out bundle for serial_and_reducer.
// slave: the reducer block itself. master: the upstream/downstream environment.
interface serial_and_reducer_if #(
  parameter int MAX_LEN = 16
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_bit;
  logic             in_last;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic             out_and;
  logic [CNT_W-1:0] out_len;
  logic             out_err;

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_and, out_len, out_err
  );

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_and, out_len, out_err
  );
endinterface

// File: rtl/serial_and_reducer.sv
// serial_and_reducer: reduces each serial frame (delimited by in_last) to the
// AND of its bits, reporting the saturated beat count and an overflow flag.
module serial_and_reducer #(
  parameter int MAX_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_and_reducer_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state, state_next;
  logic             acc, acc_next;
  logic [CNT_W-1:0] count, count_next;
  logic             ovf, ovf_next;
  logic             accept;
  logic             result_done;

  assign bus.in_ready = (state != HOLD) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign result_done  = bus.out_valid && bus.out_ready;

  // Next-state and accumulator datapath; everything holds unless a beat is accepted.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    ovf_next   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_next   = bus.in_bit;
          count_next = CNT_W'(1);
          ovf_next   = 1'b0;
          state_next = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // gate-by-mux AND step
          acc_next = bus.in_bit ? acc : 1'b0;
          if (count == MAX_CNT) begin
            count_next = MAX_CNT;
            ovf_next   = 1'b1;
          end else begin
            count_next = count + CNT_W'(1);
          end
          if (bus.in_last) state_next = HOLD;
        end
      end
      HOLD: begin
        if (result_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and frame accumulator registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 1'b0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      ovf   <= ovf_next;
    end
  end

  // Result registers: loaded from the final beat's next values, held through HOLD and beyond.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_and   <= 1'b0;
      bus.out_len   <= '0;
      bus.out_err   <= 1'b0;
    end else if (accept && bus.in_last) begin
      bus.out_valid <= 1'b1;
      bus.out_and   <= acc_next;
      bus.out_len   <= count_next;
      bus.out_err   <= ovf_next;
    end else if (result_done) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_serial_and_reducer.sv
// Self-checking bench for serial_and_reducer: a frame model pushes expected
// results to a scoreboard queue; results are popped when the DUT presents them.
module tb_serial_and_reducer;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic             a;
    logic [CNT_W-1:0] len;
    logic             err;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  res_t sb[$];

  serial_and_reducer_if #(.MAX_LEN(MAX_LEN)) bus ();

  serial_and_reducer #(.MAX_LEN(MAX_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input bit bits[$]);
    res_t r;
    int unsigned n;
    r.a = 1'b1;
    foreach (bits[i]) r.a = r.a & bits[i];
    n = bits.size();
    r.err = (n > MAX_LEN);
    r.len = (n > MAX_LEN) ? CNT_W'(MAX_LEN) : CNT_W'(n);
    return r;
  endfunction

  task automatic send_beat(input bit b, input bit last);
    int n;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_last  = last;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  task automatic send_frame(input bit bits[$], input bit gaps);
    sb.push_back(model(bits));
    foreach (bits[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_bit   = 1'($urandom);
          bus.in_last  = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      send_beat(bits[i], i == bits.size() - 1);
    end
  endtask

  task automatic wait_result(input string name);
    res_t exp;
    int   n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: out_valid=%b required 1", name, bus.out_valid);
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: out_valid=1 with empty scoreboard required none", name);
      return;
    end
    exp = sb.pop_front();
    if ({bus.out_and, bus.out_len, bus.out_err} !== {exp.a, exp.len, exp.err}) begin
      errors++;
      $display("FAIL %s_result: and=%b len=%0d err=%b required and=%b len=%0d err=%b",
               name, bus.out_and, bus.out_len, bus.out_err, exp.a, exp.len, exp.err);
    end
    if (bus.out_ready === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_and, bus.out_len, bus.out_err} !==
        {1'b1, 1'b0, 1'b0, CNT_W'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b v=%b and=%b len=%0d err=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_and, bus.out_len, bus.out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    send_frame('{1, 1, 1, 1}, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b in_ready=%b required 1 0", bus.out_valid, bus.in_ready);
    end
    wait_result("basic_1111");
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_mixed();
    send_frame('{1, 0, 1}, 1'b0);
    wait_result("mixed_101");
    send_frame('{1, 1}, 1'b0);
    wait_result("mixed_11");
  endtask

  task automatic test_single();
    send_frame('{0}, 1'b0);
    wait_result("single_0");
    send_frame('{1}, 1'b0);
    wait_result("single_1");
  endtask

  task automatic test_overflow();
    bit bits[$];
    for (int unsigned i = 0; i < 18; i++) bits.push_back(1'b1);
    send_frame(bits, 1'b0);
    wait_result("ovf_18");
    send_frame('{1, 1}, 1'b0);
    wait_result("ovf_after");
  endtask

  task automatic test_stall();
    res_t exp;
    bus.out_ready = 1'b0;
    send_frame('{1, 1, 0, 1, 1}, 1'b1);
    exp = sb[0];
    // upstream presents a beat during HOLD; it must wait
    bus.in_valid = 1'b1; bus.in_bit = 1'b0; bus.in_last = 1'b1;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.out_and, bus.out_len, bus.out_err} !==
          {1'b1, 1'b0, exp.a, exp.len, exp.err}) begin
        errors++;
        $display("FAIL stall_hold%0d: v=%b rdy=%b and=%b len=%0d err=%b required v=1 rdy=0 and=%b len=%0d err=%b",
                 c, bus.out_valid, bus.in_ready, bus.out_and, bus.out_len, bus.out_err,
                 exp.a, exp.len, exp.err);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    wait_result("stall_result");
    send_frame('{0}, 1'b0);
    wait_result("stall_pending");
  endtask

  task automatic test_reset_abort();
    send_frame('{1, 1}, 1'b0);
    wait_result("abort_pre");
    send_beat(1'b1, 1'b0);
    send_beat(1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_in_ready: got %b required 0", bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_and, bus.out_len, bus.out_err} !==
        {1'b1, 1'b0, 1'b0, CNT_W'(0), 1'b0}) begin
      errors++;
      $display("FAIL abort_outputs: rdy=%b v=%b and=%b len=%0d err=%b required 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.out_and, bus.out_len, bus.out_err);
    end
    @(posedge clk); #1;
    send_frame('{1, 1, 1}, 1'b0);
    wait_result("abort_next");
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL final_idle: out_valid=%b pending=%0d required 0 0", bus.out_valid, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_single();
    test_overflow();
    test_stall();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
